// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared fetch-stage types and constants.
// RESET_PC is also the program counter's reset value.
package rv_fetch_pkg;
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;
   localparam logic [31:0] NOP_INSN = 32'h00000013;
   localparam logic [31:0] RESET_PC = 32'h01000000;
endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: one-entry holding register presenting a fetched instruction to decode.
// Clear or a decode handshake drops valid; the payload stays put until the next load.
module fetch_out_buf
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC_P = RESET_PC,
   parameter logic [31:0] NOP_INSN_P = NOP_INSN
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        clr_i,
   input  logic        ready_i,
   input  logic [31:0] data_i,
   input  logic [31:0] pc_i,
   input  logic        fault_i,
   output logic        valid_o,
   output logic [31:0] data_o,
   output logic [31:0] pc_o,
   output logic        fault_o
);
   logic        valid_q;
   logic [31:0] data_q;
   logic [31:0] pc_q;
   logic        fault_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= NOP_INSN_P;
         pc_q    <= RESET_PC_P;
         fault_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         pc_q    <= pc_i;
         fault_q <= fault_i;
      end else if (clr_i || (valid_q && ready_i)) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;
   assign fault_o = fault_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: non-pipelined instruction fetch, one outstanding imem read at a time.
// Redirects squash in-flight work; misaligned PCs produce a faulted NOP without a request.
module instr_fetch
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC_P = RESET_PC,
   parameter logic [31:0] NOP_INSN_P = NOP_INSN
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pc_advance,
   input  logic        redirect,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   input  logic        inst_ready
);
   state_t      state_q, state_d;
   logic        discard_q, discard_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        load;
   logic [31:0] ld_data, ld_pc;
   logic        ld_fault;
   logic        misaligned;

   assign misaligned     = pc[1:0] != 2'b00;
   assign imem_req_valid = rst && state_q == S_REQ && !redirect && !misaligned;
   assign imem_req_addr  = pc;
   assign pc_advance     = imem_req_valid && imem_req_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_REQ;
         discard_q <= 1'b0;
         req_pc_q  <= RESET_PC_P;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         req_pc_q  <= req_pc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      req_pc_d  = req_pc_q;
      load      = 1'b0;
      ld_data   = NOP_INSN_P;
      ld_pc     = pc;
      ld_fault  = 1'b0;
      case (state_q)
         S_REQ: begin
            if (!redirect && misaligned) begin
               load     = 1'b1;
               ld_fault = 1'b1;
               state_d  = S_HOLD;
            end else if (!redirect && imem_req_ready) begin
               req_pc_d = pc;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            // a response that races a redirect belongs to the squashed path
            if (imem_rsp_valid) begin
               discard_d = 1'b0;
               state_d   = S_REQ;
               if (!discard_q && !redirect) begin
                  load    = 1'b1;
                  ld_data = imem_rsp_data;
                  ld_pc   = req_pc_q;
                  state_d = S_HOLD;
               end
            end else if (redirect) begin
               discard_d = 1'b1;
            end
         end
         S_HOLD: state_d = (redirect || inst_ready) ? S_REQ : S_HOLD;
         default: state_d = S_REQ;
      endcase
   end

   fetch_out_buf #(
      .RESET_PC_P(RESET_PC_P),
      .NOP_INSN_P(NOP_INSN_P)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .clr_i   (redirect),
      .ready_i (inst_ready),
      .data_i  (ld_data),
      .pc_i    (ld_pc),
      .fault_i (ld_fault),
      .valid_o (inst_valid),
      .data_o  (inst_data),
      .pc_o    (inst_pc),
      .fault_o (inst_fault)
   );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios followed by randomized traffic against a
// transaction-level model of fetch (idle / outstanding request / presented instruction).
module tb_instr_fetch;
   localparam logic [31:0] RPC = 32'h01000000;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pc_advance;
   logic        redirect;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        inst_ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .pc_advance     (pc_advance),
      .redirect       (redirect),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault),
      .inst_ready     (inst_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // model of what fetch should be doing, plus the memory's pending response
   bit          m_busy, m_kill, m_hold, adv_seen, pend;
   logic [31:0] m_addr, h_data, h_pc, tgt;
   logic        h_fault;
   int          cyc, rsp_at, delivered;
   bit          exp_req;

   initial begin
      rst = 1'b0; pc = RPC; redirect = 1'b0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_adv", pc_advance, 0);
      chk("rst_ivalid", inst_valid, 0);
      chk("rst_idata", inst_data, NOP);
      chk("rst_ipc", inst_pc, RPC);
      chk("rst_ifault", inst_fault, 0);
      // first fetch
      rst = 1'b1; imem_req_ready = 1'b1;
      #1;
      chk("f1_req_valid", imem_req_valid, 1);
      chk("f1_adv", pc_advance, 1);
      chk("f1_addr", imem_req_addr, RPC);
      @(posedge clk); #1;
      pc = RPC + 4; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093;
      @(negedge clk);
      chk("f1_wait_adv", pc_advance, 0);
      chk("f1_wait_ivalid", inst_valid, 0);
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("f1_ivalid", inst_valid, 1);
      chk("f1_idata", inst_data, 32'h00500093);
      chk("f1_ipc", inst_pc, RPC);
      chk("f1_ifault", inst_fault, 0);
      // decode backpressure
      repeat (5) begin
         @(posedge clk); @(negedge clk);
         chk("bp_ivalid", inst_valid, 1);
         chk("bp_idata", inst_data, 32'h00500093);
         chk("bp_req_valid", imem_req_valid, 0);
         chk("bp_adv", pc_advance, 0);
      end
      @(posedge clk); #1; inst_ready = 1'b1;
      @(posedge clk); #1; inst_ready = 1'b0; imem_req_ready = 1'b0;
      @(negedge clk);
      chk("bp_rel_ivalid", inst_valid, 0);
      chk("bp_rel_req", imem_req_valid, 1);
      chk("bp_rel_addr", imem_req_addr, RPC + 4);
      // async reset while waiting on memory
      imem_req_ready = 1'b1;
      @(posedge clk); #1; imem_req_ready = 1'b0; pc = RPC + 8;
      #2; rst = 1'b0; #1;
      chk("ar_ivalid", inst_valid, 0);
      chk("ar_idata", inst_data, NOP);
      chk("ar_req_valid", imem_req_valid, 0);
      chk("ar_adv", pc_advance, 0);
      pc = RPC;
      @(negedge clk); #1;
      rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF; #1;
      chk("ar_fresh_req", imem_req_valid, 1);
      @(posedge clk); #1; imem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("ar_stale_ivalid", inst_valid, 0);
      chk("ar_stale_req", imem_req_valid, 1);
      // misaligned pc
      pc = RPC + 2; #1;
      chk("mis_req_valid", imem_req_valid, 0);
      chk("mis_adv", pc_advance, 0);
      @(negedge clk);
      chk("mis_ivalid", inst_valid, 1);
      chk("mis_ifault", inst_fault, 1);
      chk("mis_idata", inst_data, NOP);
      chk("mis_ipc", inst_pc, RPC + 2);
      chk("mis_hold_adv", pc_advance, 0);
      inst_ready = 1'b1;
      @(posedge clk); #1; inst_ready = 1'b0; pc = RPC + 8; imem_req_ready = 1'b1;
      // redirect while waiting, response two cycles later is dropped
      @(posedge clk); #1; imem_req_ready = 1'b0; redirect = 1'b1;
      @(posedge clk); #1; redirect = 1'b0; pc = RPC + 32'h40;
      @(posedge clk); #1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
      @(posedge clk); #1; imem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("rd_ivalid", inst_valid, 0);
      chk("rd_req_valid", imem_req_valid, 1);
      chk("rd_addr", imem_req_addr, RPC + 32'h40);
      // randomized traffic
      m_busy = 0; m_kill = 0; m_hold = 0; pend = 0; adv_seen = 0;
      cyc = 0; rsp_at = 0; delivered = 0; tgt = pc;
      for (int n = 0; n < 3000; n++) begin
         exp_req = !m_busy && !m_hold && !redirect && pc[1:0] == 2'b00;
         chk("r_req_valid", imem_req_valid, exp_req);
         chk("r_adv", pc_advance, exp_req && imem_req_ready);
         if (exp_req) chk("r_addr", imem_req_addr, pc);
         chk("r_ivalid", inst_valid, m_hold);
         if (m_hold) begin
            chk("r_idata", inst_data, h_data);
            chk("r_ipc", inst_pc, h_pc);
            chk("r_ifault", inst_fault, h_fault);
         end
         adv_seen = exp_req && imem_req_ready;
         if (!m_busy && !m_hold) begin
            if (!redirect && pc[1:0] != 2'b00) begin
               m_hold = 1; h_data = NOP; h_pc = pc; h_fault = 1;
            end else if (adv_seen) begin
               m_busy = 1; m_kill = 0; m_addr = pc;
               pend = 1; rsp_at = cyc + $urandom_range(1, 3);
            end
         end else if (m_busy) begin
            if (imem_rsp_valid) begin
               m_busy = 0;
               if (!m_kill && !redirect) begin
                  m_hold = 1; h_data = mem(m_addr); h_pc = m_addr; h_fault = 0;
               end
            end else if (redirect) m_kill = 1;
         end else if (redirect || inst_ready) begin
            if (!redirect) delivered++;
            m_hold = 0;
         end
         @(posedge clk); #1;
         cyc++;
         if (redirect) pc = tgt;
         else if (adv_seen) pc = pc + 4;
         redirect = $urandom_range(0, 9) == 0;
         tgt = RPC + ($urandom_range(0, 63) << 2) + (($urandom_range(0, 7) == 0) ? 2 : 0);
         imem_req_ready = $urandom_range(0, 9) < 7;
         inst_ready = $urandom_range(0, 9) < 6;
         if (pend && cyc == rsp_at) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = mem(m_addr); pend = 0;
         end else if (!m_busy && !m_hold && $urandom_range(0, 15) == 0) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
         end else begin
            imem_rsp_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("r_delivered", delivered > 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
